sort_three_floats_stream: RTL and testbench
===========================================

Name: sort_three_floats_stream

Overview:
- Sequential counterpart of the combinational three-float sorter.
- Receives three FP values serially over a valid/ready upstream port and stores them.
- Orders them with a single time-shared f_less_or_equal instance.
- Sends them back serially, smallest first, over a valid/ready downstream port with a per-group error flag.
- Sits between an FP producer and consumer wherever only one comparator can be afforded.

Parameters:
- FLEN, global (config-shared.vh, normally 64): FP word width. Not overridable locally.
- GROUP, localparam 3: items per sort group. Fixed.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- up_valid  input  1  upstream item valid
- up_data  input  FLEN  upstream FP item
- up_ready  output  1  block can accept an item
- down_valid  output  1  sorted item valid
- down_data  output  FLEN  sorted FP item
- down_err  output  1  group error flag, valid with down_valid
- down_ready  input  1  consumer accepts item

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: up_ready=1, down_valid=0, down_data=0, down_err=0. FSM goes to LOAD, item counter 0, sticky error 0.
- Upstream transfer occurs on up_valid & up_ready. Downstream transfer occurs on down_valid & down_ready.
- Buffer: buf[0..2] of FLEN bits.
- FSM states: LOAD, CMP_A, CMP_B, CMP_C, DRAIN.
- LOAD:
  - up_ready=1.
  - Each transfer writes buf[cnt], then cnt++.
  - On the transfer with cnt==2, go to CMP_A and set cnt=0.
- CMP_A compares buf[0],buf[1]. CMP_B compares buf[1],buf[2]. CMP_C compares buf[0],buf[1].
  - Each compare state lasts exactly 1 cycle.
  - Comparator inputs are muxed from buf by state.
- Swap rule: swap the pair when comparator res==0 and err==0. Equal values are not swapped, so the sort is stable.
- Comparator err==1: no swap, and the sticky error is set.
- CMP_C goes to DRAIN.
- DRAIN:
  - down_valid=1, down_data=buf[cnt], down_err=sticky error.
  - Each downstream transfer increments cnt.
  - The transfer with cnt==2 goes to LOAD, clears cnt and clears sticky error.
  - With down_ready=0, down_data and down_err hold stable.
- Latency: last upstream transfer at cycle T gives first down_valid at T+4. With down_ready held high, one item per cycle thereafter.
- up_ready=0 in all states except LOAD. No input is accepted while sorting or draining, and there is no overlap between groups.
- down_valid=0 outside DRAIN. down_data is 0 outside DRAIN.
- rst asserted in any state: the partial group is discarded, and the block returns to reset values on the next edge.
- up_valid is ignored when up_ready=0. up_data is sampled only on a transfer.

Optional Feature:
- Macro: SORT_THREE_FLOATS_STREAM_DESCENDING_EN.
- Defined: DRAIN emits buf[2], buf[1], buf[0], giving non-increasing order. The counter counts down 2 to 0, and the transfer at cnt==0 ends the group. Compare and swap logic is unchanged.
- Undefined: ascending order as above.

Decomposition:
- Shared package sort_floats_pkg holds:
  - state enum typedef (LOAD, CMP_A, CMP_B, CMP_C, DRAIN), 3-bit encoding;
  - localparam GROUP=3;
  - counter width typedef (2 bits).
- Sub-module: reuse the existing f_less_or_equal as the sole comparator, exactly one instance.
- The rest is flat: FSM, counter, buffer and swap mux in one module.

Test Plan:
- Ascending: send 3.0 (64'h4008000000000000), 1.0 (64'h3FF0000000000000), 2.0 (64'h4000000000000000) with down_ready=1 -> first down_valid 4 cycles after the last input; outputs 1.0, 2.0, 3.0, all with down_err=0.
- Equal and negative values: send -1.0 (64'hBFF0000000000000), 2.0, -1.0 -> outputs -1.0, -1.0, 2.0, err=0. up_ready stays 0 from the cycle after the third input until the third output transfer.
- NaN: send 1.0, 64'h7FF8000000000000, 2.0 -> three outputs, each with down_err=1. The next group 2.0, 1.0, 3.0 gives 1.0, 2.0, 3.0 with err=0 (sticky error cleared).
- Backpressure: hold down_ready=0 for 5 cycles in DRAIN -> down_valid=1 and down_data=buf[0] stable throughout. Random down_ready toggling still delivers all three in order with no duplicates.
- Reset mid-operation: assert rst after 2 inputs, and again in CMP_B -> next cycle up_ready=1, down_valid=0. A fresh group of 3 sorts correctly, with no stale items emitted.
- With SORT_THREE_FLOATS_STREAM_DESCENDING_EN defined: input 1.0, 3.0, 2.0 -> outputs 3.0, 2.0, 1.0.

Source files
------------

// File: rtl/sort_floats_pkg.sv
// Shared types for the streaming three-float sorter: FSM states, counter type, group size.
package sort_floats_pkg;

    localparam int FLEN  = 64;
    localparam int GROUP = 3;

    typedef logic [1:0] cnt_t;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CMP_A = 3'd1,
        CMP_B = 3'd2,
        CMP_C = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 a <= b comparator; err flags a NaN operand (res is then 0).
module f_less_or_equal
    import sort_floats_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);

    localparam int EXP_W  = (FLEN == 32) ? 8 : 11;
    localparam int MANT_W = FLEN - 1 - EXP_W;

    logic            a_nan;
    logic            b_nan;
    logic [FLEN-2:0] mag_a;
    logic [FLEN-2:0] mag_b;

    assign mag_a = a[FLEN-2:0];
    assign mag_b = b[FLEN-2:0];
    assign a_nan = (&a[FLEN-2 -: EXP_W]) && (|a[MANT_W-1:0]);
    assign b_nan = (&b[FLEN-2 -: EXP_W]) && (|b[MANT_W-1:0]);

    always_comb begin
        err = a_nan | b_nan;
        res = 1'b0;
        if (!err) begin
            // +0 and -0 compare equal regardless of sign bit
            if (mag_a == '0 && mag_b == '0) begin
                res = 1'b1;
            end else if (a[FLEN-1] != b[FLEN-1]) begin
                res = a[FLEN-1];
            end else if (!a[FLEN-1]) begin
                res = (mag_a <= mag_b);
            end else begin
                res = (mag_a >= mag_b);
            end
        end
    end

endmodule

// File: rtl/sort_three_floats_stream.sv
// Serial three-float sorter sharing one comparator across three bubble passes.
// Define SORT_THREE_FLOATS_STREAM_DESCENDING_EN to drain in non-increasing order.
module sort_three_floats_stream
    import sort_floats_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] up_data,
    output logic            up_ready,
    output logic            down_valid,
    output logic [FLEN-1:0] down_data,
    output logic            down_err,
    input  logic            down_ready
);

`ifdef SORT_THREE_FLOATS_STREAM_DESCENDING_EN
    localparam cnt_t DRAIN_FIRST = cnt_t'(GROUP - 1);
    localparam cnt_t DRAIN_LAST  = cnt_t'(0);
`else
    localparam cnt_t DRAIN_FIRST = cnt_t'(0);
    localparam cnt_t DRAIN_LAST  = cnt_t'(GROUP - 1);
`endif

    state_t          state_reg;
    state_t          state_next;
    cnt_t            cnt_reg;
    logic            err_reg;
    logic [FLEN-1:0] buf_q [GROUP];

    cnt_t            pair_lo;
    cnt_t            pair_hi;
    logic [FLEN-1:0] cmp_x;
    logic [FLEN-1:0] cmp_y;
    logic            cmp_res;
    logic            cmp_err;
    logic            in_cmp;
    logic            swap;
    logic            up_fire;
    logic            down_fire;

    assign up_fire   = up_valid & up_ready;
    assign down_fire = down_valid & down_ready;
    assign in_cmp    = (state_reg == CMP_A) || (state_reg == CMP_B) || (state_reg == CMP_C);
    assign pair_lo   = (state_reg == CMP_B) ? cnt_t'(1) : cnt_t'(0);
    assign pair_hi   = pair_lo + cnt_t'(1);
    assign cmp_x     = buf_q[pair_lo];
    assign cmp_y     = buf_q[pair_hi];
    // Swap only on a strict out-of-order result; ties stay put so the sort is stable
    assign swap      = in_cmp && !cmp_res && !cmp_err;

    f_less_or_equal u_cmp (
        .a   (cmp_x),
        .b   (cmp_y),
        .res (cmp_res),
        .err (cmp_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        down_data  = '0;
        down_err   = 1'b0;
        case (state_reg)
            LOAD: begin
                up_ready = 1'b1;
                if (up_valid && cnt_reg == cnt_t'(GROUP - 1)) begin
                    state_next = CMP_A;
                end
            end
            CMP_A: state_next = CMP_B;
            CMP_B: state_next = CMP_C;
            CMP_C: state_next = DRAIN;
            DRAIN: begin
                down_valid = 1'b1;
                down_data  = buf_q[cnt_reg];
                down_err   = err_reg;
                if (down_ready && cnt_reg == DRAIN_LAST) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (in_cmp && cmp_err) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                LOAD: begin
                    if (up_fire) begin
                        cnt_reg <= (cnt_reg == cnt_t'(GROUP - 1)) ? cnt_t'(0) : cnt_reg + cnt_t'(1);
                    end
                end
                CMP_C: cnt_reg <= DRAIN_FIRST;
                DRAIN: begin
                    if (down_fire) begin
                        if (cnt_reg == DRAIN_LAST) begin
                            cnt_reg <= '0;
                            err_reg <= 1'b0;
                        end else begin
`ifdef SORT_THREE_FLOATS_STREAM_DESCENDING_EN
                            cnt_reg <= cnt_reg - cnt_t'(1);
`else
                            cnt_reg <= cnt_reg + cnt_t'(1);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Each slot is written by the upstream load or by the swap of the pair it belongs to
    for (genvar gi = 0; gi < GROUP; gi++) begin : g_buf
        logic [FLEN-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (up_fire && cnt_reg == cnt_t'(gi)) begin
                entry_reg <= up_data;
            end else if (swap && pair_lo == cnt_t'(gi)) begin
                entry_reg <= cmp_y;
            end else if (swap && pair_hi == cnt_t'(gi)) begin
                entry_reg <= cmp_x;
            end
        end
        assign buf_q[gi] = entry_reg;
    end

endmodule

// File: tb/tb_sort_three_floats_stream.sv
// Directed plus random bench for sort_three_floats_stream against a stable-sort reference.
module tb_sort_three_floats_stream;
    import sort_floats_pkg::*;

    typedef logic [63:0] fq_t [$];

    localparam logic [63:0] F_P1   = 64'h3FF0000000000000;
    localparam logic [63:0] F_P2   = 64'h4000000000000000;
    localparam logic [63:0] F_P3   = 64'h4008000000000000;
    localparam logic [63:0] F_N1   = 64'hBFF0000000000000;
    localparam logic [63:0] F_NAN  = 64'h7FF8000000000000;
    localparam logic [63:0] F_JUNK = 64'hDEADBEEFCAFEF00D;

    logic            clk = 1'b0;
    logic            rst;
    logic            up_valid;
    logic [FLEN-1:0] up_data;
    logic            up_ready;
    logic            down_valid;
    logic [FLEN-1:0] down_data;
    logic            down_err;
    logic            down_ready;

    int checks = 0;
    int errors = 0;
    int grp    = 0;

    sort_three_floats_stream dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_err   (down_err),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_nan(input logic [63:0] v);
        return (v[62:52] == 11'h7FF) && (v[51:0] != '0);
    endfunction

    // Stable sort by numeric value; descending build drains the same order reversed
    function automatic fq_t ref_sort(input fq_t in);
        fq_t out;
        out = {};
        foreach (in[i]) begin
            int pos = out.size();
            for (int j = 0; j < out.size(); j++) begin
                if ($bitstoreal(out[j]) > $bitstoreal(in[i])) begin
                    pos = j;
                    break;
                end
            end
            out.insert(pos, in[i]);
        end
`ifdef SORT_THREE_FLOATS_STREAM_DESCENDING_EN
        out.reverse();
`endif
        return out;
    endfunction

    function automatic logic [63:0] rnd_fp();
        logic [63:0] pool [8];
        logic [63:0] m;
        logic        s;
        logic [10:0] e;
        pool[0] = 64'h0; pool[1] = 64'h8000000000000000; pool[2] = F_P1; pool[3] = F_N1;
        pool[4] = F_P2;  pool[5] = 64'h7FF0000000000000; pool[6] = 64'hFFF0000000000000; pool[7] = F_P3;
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
        m = {$urandom(), $urandom()};
        s = 1'($urandom_range(0, 1));
        e = 11'($urandom_range(0, 2046));
        return {s, e, m[51:0]};
    endfunction

    // Leaves up_valid high with junk so the bench also sees it ignored while busy
    task automatic send_group(input fq_t items);
        foreach (items[i]) begin
            int n = 0;
            up_valid = 1'b1;
            up_data  = items[i];
            while (!up_ready && n < 50) begin
                step();
                n++;
            end
            chk("up_ready_wait", 64'(up_ready), 64'd1);
            step();
        end
        up_data = F_JUNK;
    endtask

    // mode 0: ready held high, 1: random ready, 2: five stalled cycles then ready
    task automatic recv_group(input fq_t exp, input bit exp_nan, input int mode);
        int n = 0;
        down_ready = (mode == 0);
        while (!down_valid && n < 20) begin
            chk("busy_up_ready", 64'(up_ready), 64'd0);
            step();
            n++;
        end
        chk("latency", 64'(n), 64'd3);
        if (mode == 2) begin
            down_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                chk("stall_valid", 64'(down_valid), 64'd1);
                chk("stall_data", down_data, exp[0]);
                step();
            end
        end
        for (int i = 0; i < GROUP; i++) begin
            int  w    = 0;
            bit  done = 1'b0;
            while (!done) begin
                down_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (down_ready || w >= 50) begin
                    done = 1'b1;
                end else begin
                    chk("hold_valid", 64'(down_valid), 64'd1);
                    if (!exp_nan) chk("hold_data", down_data, exp[i]);
                    step();
                    w++;
                end
            end
            chk("out_valid", 64'(down_valid), 64'd1);
            chk("out_err", 64'(down_err), 64'(exp_nan));
            if (!exp_nan) chk("out_data", down_data, exp[i]);
            chk("drain_up_ready", 64'(up_ready), 64'd0);
            $display("group %0d item %0d data=%h err=%b", grp, i, down_data, down_err);
            if (i == GROUP - 1) up_valid = 1'b0;
            step();
        end
        down_ready = 1'b0;
        chk("done_up_ready", 64'(up_ready), 64'd1);
        chk("done_valid", 64'(down_valid), 64'd0);
        chk("done_data", down_data, 64'd0);
        grp++;
    endtask

    task automatic run_group(input fq_t items, input int mode);
        bit nan = 1'b0;
        foreach (items[i]) if (is_nan(items[i])) nan = 1'b1;
        send_group(items);
        recv_group(nan ? items : ref_sort(items), nan, mode);
    endtask

    initial begin
        fq_t g;
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        down_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_up_ready", 64'(up_ready), 64'd1);
        chk("rst_down_valid", 64'(down_valid), 64'd0);
        chk("rst_down_data", down_data, 64'd0);
        chk("rst_down_err", 64'(down_err), 64'd0);

        g = {F_P3, F_P1, F_P2};  run_group(g, 0);
        g = {F_N1, F_P2, F_N1};  run_group(g, 0);
        g = {F_P1, F_NAN, F_P2}; run_group(g, 0);
        g = {F_P2, F_P1, F_P3};  run_group(g, 0);
        g = {F_P3, F_N1, F_P2};  run_group(g, 2);
        g = {F_P2, F_P3, F_P1};  run_group(g, 1);

        // reset after two inputs
        up_valid = 1'b1; up_data = F_JUNK; step();
        up_data = F_JUNK; step();
        rst = 1'b1; up_valid = 1'b0; step();
        rst = 1'b0;
        chk("rst_load_up_ready", 64'(up_ready), 64'd1);
        chk("rst_load_valid", 64'(down_valid), 64'd0);

        // reset while in CMP_B
        g = {F_JUNK, F_P1, F_P2};
        send_group(g);
        step();
        rst = 1'b1; up_valid = 1'b0; step();
        rst = 1'b0;
        chk("rst_cmp_up_ready", 64'(up_ready), 64'd1);
        chk("rst_cmp_valid", 64'(down_valid), 64'd0);
        step();
        chk("rst_cmp_idle_valid", 64'(down_valid), 64'd0);
        g = {F_P1, F_P3, F_P2};  run_group(g, 0);

        for (int r = 0; r < 25; r++) begin
            g = {rnd_fp(), rnd_fp(), rnd_fp()};
            if (r % 8 == 7) g[$urandom_range(0, 2)] = F_NAN;
            run_group(g, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
